// File: rtl/fpu_exp_pkg.sv
// rtl/fpu_exp_pkg.sv - shared width, opcode encoding and stage payload types for the FPU exponent pipe
package fpu_exp_pkg;

  localparam int W = 15;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef struct packed {
    logic [W-1:0] s;
    logic [W-1:0] k;
    logic         cin;
  } exp_s1_t;

  typedef struct packed {
    logic [W-1:0] exp;
    logic         ovf;
    logic         unf;
  } exp_res_t;

endpackage

// File: rtl/bk15.sv
// rtl/bk15.sv - 15-bit Brent-Kung prefix adder with carry-in, result mod 2^15
module bk15 (
  input  logic [14:0] a,
  input  logic [14:0] b,
  input  logic        cin,
  output logic [14:0] sum
);

  logic [14:0] p;
  logic [13:0] g;
  logic [13:0] gg;
  logic [13:0] pp;

  // gg[i] ends up as the carry out of bit i; the carry out of bit 14 is never needed.
  always_comb begin
    p  = a ^ b;
    g  = a[13:0] & b[13:0];
    gg = g;
    pp = p[13:0];
    gg[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < 14; d = d * 2) begin
      for (int i = 2 * d - 1; i < 14; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    for (int d = 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < 14; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
      end
    end
    sum = p ^ {gg, cin};
  end

endmodule

// File: rtl/csa3_15.sv
// rtl/csa3_15.sv - 15-bit 3:2 carry-save compressor
module csa3_15
  import fpu_exp_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] k
);

  logic [W-1:0] maj;

  assign maj = (a & b) | (a & c) | (b & c);
  assign s   = a ^ b ^ c;
  // Carry out of the top bit falls off: the sum is taken mod 2^W.
  assign k   = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/fpu_exp_pipe.sv
// rtl/fpu_exp_pipe.sv - two-stage valid/ready MUL/DIV exponent datapath (CSA + bk15)
// FPU_EXP_SKID_EN adds a registered-ready skid buffer ahead of S1.
module fpu_exp_pipe
  import fpu_exp_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int BIAS  = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic             InOp,
  input  logic [EXP_W-1:0] XA,
  input  logic [EXP_W-1:0] XB,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [W-1:0]     ExpOut,
  output logic             ExpOvf,
  output logic             ExpUnf
);

  localparam logic [W-1:0] BIAS_W   = W'(BIAS);
  localparam logic [W-1:0] NEG_BIAS = (~BIAS_W) + W'(1);
  localparam logic [W-1:0] OVF_LIM  = W'((1 << EXP_W) - 1);

  logic             s1_valid;
  exp_s1_t          s1_q;
  exp_s1_t          s1_d;
  logic             s2_valid;
  exp_res_t         s2_q;
  exp_res_t         res_d;
  logic             s1_load;
  logic             s2_load;

  logic             src_op;
  logic [EXP_W-1:0] src_xa;
  logic [EXP_W-1:0] src_xb;
  logic [W-1:0]     opa;
  logic [W-1:0]     opb;
  logic [W-1:0]     opc;
  logic [W-1:0]     csa_s;
  logic [W-1:0]     csa_k;
  logic [W-1:0]     sum_e;

  assign s2_load = !s2_valid || OutReady;
  assign s1_load = !s1_valid || s2_load;

  // DIV forms XA + ~XB + 1 + BIAS, i.e. XA - XB + BIAS.
  always_comb begin
    opa = {{(W-EXP_W){1'b0}}, src_xa};
    opb = {{(W-EXP_W){1'b0}}, src_xb};
    opc = NEG_BIAS;
    if (src_op == OP_DIV) begin
      opb = ~opb;
      opc = BIAS_W;
    end
  end

  csa3_15 u_csa (
    .a (opa),
    .b (opb),
    .c (opc),
    .s (csa_s),
    .k (csa_k)
  );

  assign s1_d = '{s: csa_s, k: csa_k, cin: (src_op == OP_DIV)};

`ifdef FPU_EXP_SKID_EN
  logic             skid_valid;
  logic             skid_op;
  logic [EXP_W-1:0] skid_xa;
  logic [EXP_W-1:0] skid_xb;

  assign InReady = !skid_valid;
  assign src_op  = skid_valid ? skid_op : InOp;
  assign src_xa  = skid_valid ? skid_xa : XA;
  assign src_xb  = skid_valid ? skid_xb : XB;

  // The skid entry is always older than anything on the inputs, so it drains into S1 first.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_q       <= '0;
      skid_valid <= 1'b0;
      skid_op    <= 1'b0;
      skid_xa    <= '0;
      skid_xb    <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= skid_valid || InValid;
        if (skid_valid || InValid) s1_q <= s1_d;
        skid_valid <= 1'b0;
      end else if (InValid && !skid_valid) begin
        skid_valid <= 1'b1;
        skid_op    <= InOp;
        skid_xa    <= XA;
        skid_xb    <= XB;
      end
    end
  end
`else
  assign InReady = s1_load;
  assign src_op  = InOp;
  assign src_xa  = XA;
  assign src_xb  = XB;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= InValid;
      if (InValid) s1_q <= s1_d;
    end
  end
`endif

  bk15 u_bk15 (
    .a   (s1_q.s),
    .b   (s1_q.k),
    .cin (s1_q.cin),
    .sum (sum_e)
  );

  always_comb begin
    res_d.exp = sum_e;
    res_d.ovf = !sum_e[W-1] && (sum_e >= OVF_LIM);
    res_d.unf = sum_e[W-1] || (sum_e == '0);
  end

  // Result registers only change on a real S1 -> S2 transfer, keeping outputs quiet on bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= res_d;
    end
  end

  assign OutValid = s2_valid;
  assign ExpOut   = s2_q.exp;
  assign ExpOvf   = s2_q.ovf;
  assign ExpUnf   = s2_q.unf;

endmodule

// File: tb/tb_fpu_exp_pipe.sv
// tb/tb_fpu_exp_pipe.sv - directed self-checking bench for fpu_exp_pipe
module tb_fpu_exp_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        InValid;
  logic        InReady;
  logic        InOp;
  logic [10:0] XA;
  logic [10:0] XB;
  logic        OutValid;
  logic        OutReady;
  logic [14:0] ExpOut;
  logic        ExpOvf;
  logic        ExpUnf;

  always #5 clk = ~clk;

  fpu_exp_pipe dut (
    .clk      (clk),
    .reset    (reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .InOp     (InOp),
    .XA       (XA),
    .XB       (XB),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .ExpOut   (ExpOut),
    .ExpOvf   (ExpOvf),
    .ExpUnf   (ExpUnf)
  );

`ifdef FPU_EXP_SKID_EN
  localparam int INFLIGHT = 3;
`else
  localparam int INFLIGHT = 2;
`endif

  typedef struct {
    logic        op;
    logic [10:0] xa;
    logic [10:0] xb;
    logic [16:0] exp;
  } stim_t;

  stim_t       stim_q[$];
  logic [16:0] exp_q[$];
  int          acc_cyc[$];
  int          out_cyc[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        held_v = 1'b0;
  logic [16:0] held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] pk(input logic [14:0] e, input logic o, input logic u);
    return {e, o, u};
  endfunction

  function automatic logic [16:0] model(input logic op, input int xa, input int xb);
    int e;
    e = op ? (xa - xb + 1023) : (xa + xb - 1023);
    return {e[14:0], e >= 2047, e <= 0};
  endfunction

  task automatic push(input logic op, input int xa, input int xb, input logic [16:0] exp);
    stim_t s;
    s.op = op; s.xa = 11'(xa); s.xb = 11'(xb); s.exp = exp;
    stim_q.push_back(s);
  endtask

  task automatic push_rand();
    int a, b;
    logic op;
    a  = $urandom_range(1, 2046);
    b  = $urandom_range(1, 2046);
    op = 1'($urandom_range(0, 1));
    push(op, a, b, model(op, a, b));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    check({tag, "_drained"}, 32'(n < 300), 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Driver: presents the queue head, retires it when the handshake will complete.
  initial begin
    InValid = 1'b0; InOp = 1'b0; XA = '0; XB = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stim_q.size() != 0) begin
        InValid = 1'b1; InOp = stim_q[0].op; XA = stim_q[0].xa; XB = stim_q[0].xb;
      end else begin
        InValid = 1'b0;
      end
      @(negedge clk);
      if (InValid && InReady && !reset) begin
        exp_q.push_back(stim_q[0].exp);
        acc_cyc.push_back(cyc);
        void'(stim_q.pop_front());
      end
    end
  end

  // Monitor: scoreboard on output transfers, plus output stability while stalled.
  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v && OutValid) check("stall_hold", {ExpOut, ExpOvf, ExpUnf}, held);
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
        else begin
          check("result", {ExpOut, ExpOvf, ExpUnf}, exp_q.pop_front());
          out_cyc.push_back(cyc);
        end
      end
      held_v = OutValid && !OutReady;
      held   = {ExpOut, ExpOvf, ExpUnf};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    reset = 1'b1;
    OutReady = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_outvalid", OutValid, 0);
    check("rst_expout", ExpOut, 0);
    check("rst_flags", {ExpOvf, ExpUnf}, 0);
    check("rst_inready", InReady, 1);

    // Directed values, including the overflow/underflow thresholds.
    @(posedge clk); #2 OutReady = 1'b1;
    push(1'b0, 1023, 1023, pk(15'h03FF, 1'b0, 1'b0));
    push(1'b0, 2046, 2046, pk(15'h0BFD, 1'b1, 1'b0));
    push(1'b0, 1,    1,    pk(15'h7C03, 1'b0, 1'b1));
    push(1'b1, 1023, 1023, pk(15'h03FF, 1'b0, 1'b0));
    push(1'b1, 1,    2046, pk(15'h7C02, 1'b0, 1'b1));
    push(1'b1, 1024, 1023, pk(15'h0400, 1'b0, 1'b0));
    push(1'b0, 1024, 2046, pk(15'h07FF, 1'b1, 1'b0));
    push(1'b0, 1023, 2046, pk(15'h07FE, 1'b0, 1'b0));
    push(1'b0, 1023, 1,    pk(15'h0001, 1'b0, 1'b0));
    push(1'b0, 1022, 1,    pk(15'h0000, 1'b0, 1'b1));
    drain("directed");
    check("latency", 32'(out_cyc[0] - acc_cyc[0]), 32'd2);

    // Back-to-back random burst at full throughput.
    base = out_cyc.size();
    for (int i = 0; i < 8; i++) push_rand();
    drain("burst");
    check("burst_count", 32'(out_cyc.size() - base), 32'd8);
    if (out_cyc.size() >= base + 8)
      check("burst_rate", 32'(out_cyc[base+7] - out_cyc[base]), 32'd7);

    // Stall with input pressure, then release.
    @(posedge clk); #2 OutReady = 1'b0;
    for (int i = 0; i < 6; i++) push_rand();
    repeat (6) @(negedge clk);
    #1;
    check("stall_inready", InReady, 0);
    check("stall_inflight", 32'(exp_q.size()), 32'(INFLIGHT));
    @(posedge clk); #2 OutReady = 1'b1;
    drain("stall");

    // Reset with the pipe full and stalled.
    @(posedge clk); #2 OutReady = 1'b0;
    for (int i = 0; i < 4; i++) push_rand();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (InReady && n < 20);
    check("fill_before_reset", InReady, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    stim_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_outvalid", OutValid, 0);
    check("midrst_expout", ExpOut, 0);
    check("midrst_flags", {ExpOvf, ExpUnf}, 0);
    exp_q.delete();
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    check("postrst_inready", InReady, 1);
    @(posedge clk); #2 OutReady = 1'b1;
    push(1'b0, 1500, 600, pk(15'h0435, 1'b0, 1'b0));
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
